// File: rtl/regfile_sb_if.sv
// Decode/write-back bundle for the register file scoreboard.
// The master side drives addresses, issue and write-back; the slave side returns read data, stall and busy count.
interface regfile_sb_if #(
    parameter int XLEN = 32
);
    logic [4:0]      rs1_addr_i;
    logic [4:0]      rs2_addr_i;
    logic [XLEN-1:0] rs1_data_o;
    logic [XLEN-1:0] rs2_data_o;
    logic            issue_valid_i;
    logic            issue_wen_i;
    logic [4:0]      issue_rd_i;
    logic            stall_o;
    logic            wb_wen_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            flush_i;
    logic [5:0]      busy_cnt_o;

    modport master (
        output rs1_addr_i, rs2_addr_i, issue_valid_i, issue_wen_i, issue_rd_i,
        output wb_wen_i, wb_rd_i, wb_data_i, flush_i,
        input  rs1_data_o, rs2_data_o, stall_o, busy_cnt_o
    );

    modport slave (
        input  rs1_addr_i, rs2_addr_i, issue_valid_i, issue_wen_i, issue_rd_i,
        input  wb_wen_i, wb_rd_i, wb_data_i, flush_i,
        output rs1_data_o, rs2_data_o, stall_o, busy_cnt_o
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with write-back scoreboard; reads, bypass and stall are combinational (0 cycles).
// Backpressure: stall_o holds decode whenever a source or destination has an outstanding writer.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    logic [XLEN-1:0] r_regs [1:NREG-1];
    logic [NREG-1:0] r_busy;
    logic [5:0]      r_busy_cnt;

    logic            w_wb_act;
    logic            w_stall;
    logic            w_issue;
    logic [NREG-1:0] w_eb;
    logic [NREG-1:0] w_busy_nxt;
    logic [5:0]      w_cnt_nxt;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_wb_act = bus.wb_wen_i && (bus.wb_rd_i != 5'd0);

    // A register being written back this cycle is no longer a hazard.
    always_comb begin
        w_eb    = r_busy;
        w_eb[0] = 1'b0;
        if (w_wb_act) w_eb[bus.wb_rd_i] = 1'b0;
    end

    assign w_stall = bus.issue_valid_i &&
                     (w_eb[bus.rs1_addr_i] || w_eb[bus.rs2_addr_i] ||
                      (bus.issue_wen_i && w_eb[bus.issue_rd_i]));

    assign w_issue = bus.issue_valid_i && !w_stall && bus.issue_wen_i &&
                     (bus.issue_rd_i != 5'd0);

    // Set after clear so a new writer keeps ownership; flush overrides both.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_act) w_busy_nxt[bus.wb_rd_i] = 1'b0;
        if (w_issue)  w_busy_nxt[bus.issue_rd_i] = 1'b1;
        if (bus.flush_i) w_busy_nxt = '0;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = 6'd0;
        for (int i = 1; i < NREG; i++) w_cnt_nxt = w_cnt_nxt + {5'd0, w_busy_nxt[i]};
    end

    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        for (int i = 1; i < NREG; i++) begin
            if (bus.rs1_addr_i == 5'(i)) w_rs1_data = r_regs[i];
            if (bus.rs2_addr_i == 5'(i)) w_rs2_data = r_regs[i];
        end
        if (w_wb_act && (bus.wb_rd_i == bus.rs1_addr_i)) w_rs1_data = bus.wb_data_i;
        if (w_wb_act && (bus.wb_rd_i == bus.rs2_addr_i)) w_rs2_data = bus.wb_data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++)
                if (w_wb_act && (bus.wb_rd_i == 5'(i))) r_regs[i] <= bus.wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy     <= '0;
            r_busy_cnt <= 6'd0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign bus.rs1_data_o = w_rs1_data;
    assign bus.rs2_data_o = w_rs2_data;
    assign bus.stall_o    = w_stall;
    assign bus.busy_cnt_o = r_busy_cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a randomised run against a reference model.
module tb_regfile_sb;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    regfile_sb_if #(.XLEN(32)) bus ();

    regfile_sb #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    exp_t        sb_q[$];
    int          cnt_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    task automatic idle();
        bus.rs1_addr_i    = 5'd0;
        bus.rs2_addr_i    = 5'd0;
        bus.issue_valid_i = 1'b0;
        bus.issue_wen_i   = 1'b0;
        bus.issue_rd_i    = 5'd0;
        bus.wb_wen_i      = 1'b0;
        bus.wb_rd_i       = 5'd0;
        bus.wb_data_i     = 32'd0;
        bus.flush_i       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        bus.issue_valid_i = 1'b1;
        bus.issue_wen_i   = 1'b1;
        bus.issue_rd_i    = rd;
        bus.rs1_addr_i    = s1;
        bus.rs2_addr_i    = s2;
    endtask

    task automatic test_reset();
        idle();
        bus.wb_wen_i = 1'b1; bus.wb_rd_i = 5'd5; bus.wb_data_i = 32'hAAAA5555;
        issue(5'd5, 5'd0, 5'd0);
        tick();
        idle();
        issue(5'd31, 5'd0, 5'd0);
        tick();
        idle();
        n_checks++;
        if (bus.busy_cnt_o !== 6'd2) begin
            n_fail++; $display("FAIL reset_pre_cnt got %0d want 2", bus.busy_cnt_o);
        end
        bus.rs1_addr_i = 5'd5;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (bus.busy_cnt_o !== 6'd0) begin
            n_fail++; $display("FAIL reset_async_cnt got %0d want 0", bus.busy_cnt_o);
        end
        n_checks++;
        if (bus.rs1_data_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_async_x5 got %h want 0", bus.rs1_data_o);
        end
        @(negedge clk) rst = 1'b1;
        tick();
        bus.issue_valid_i = 1'b1;
        bus.rs1_addr_i = 5'd5;
        bus.rs2_addr_i = 5'd31;
        #2;
        n_checks++;
        if (bus.rs1_data_o !== 32'd0 || bus.rs2_data_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_read got %h/%h want 0/0", bus.rs1_data_o, bus.rs2_data_o);
        end
        n_checks++;
        if (bus.stall_o !== 1'b0 || bus.busy_cnt_o !== 6'd0) begin
            n_fail++; $display("FAIL reset_stall_cnt got %b/%0d want 0/0", bus.stall_o, bus.busy_cnt_o);
        end
        tick();
        idle();
    endtask

    task automatic test_bypass();
        idle();
        bus.wb_wen_i = 1'b1; bus.wb_rd_i = 5'd3; bus.wb_data_i = 32'h12345678;
        bus.rs1_addr_i = 5'd3;
        #2;
        n_checks++;
        if (bus.rs1_data_o !== 32'h12345678) begin
            n_fail++; $display("FAIL bypass_same got %h want 12345678", bus.rs1_data_o);
        end
        tick();
        bus.wb_wen_i = 1'b0;
        #2;
        n_checks++;
        if (bus.rs1_data_o !== 32'h12345678) begin
            n_fail++; $display("FAIL bypass_stored got %h want 12345678", bus.rs1_data_o);
        end
        tick();
        bus.wb_wen_i = 1'b1; bus.wb_rd_i = 5'd0; bus.wb_data_i = 32'hFFFFFFFF;
        bus.rs1_addr_i = 5'd0; bus.rs2_addr_i = 5'd0;
        #2;
        n_checks++;
        if (bus.rs1_data_o !== 32'd0 || bus.rs2_data_o !== 32'd0) begin
            n_fail++; $display("FAIL x0_bypass got %h/%h want 0/0", bus.rs1_data_o, bus.rs2_data_o);
        end
        tick();
        bus.wb_wen_i = 1'b0;
        bus.rs2_addr_i = 5'd3;
        #2;
        n_checks++;
        if (bus.rs1_data_o !== 32'd0 || bus.rs2_data_o !== 32'h12345678) begin
            n_fail++; $display("FAIL x0_after got %h/%h want 0/12345678", bus.rs1_data_o, bus.rs2_data_o);
        end
        tick();
        idle();
    endtask

    task automatic test_raw();
        idle();
        issue(5'd7, 5'd0, 5'd0);
        #2;
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL raw_first got %b want 0", bus.stall_o);
        end
        tick();
        idle();
        bus.issue_valid_i = 1'b1;
        bus.rs2_addr_i = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #2;
            n_checks++;
            if (bus.stall_o !== 1'b1) begin
                n_fail++; $display("FAIL raw_hold%0d got %b want 1", k, bus.stall_o);
            end
            tick();
        end
        bus.wb_wen_i = 1'b1; bus.wb_rd_i = 5'd7; bus.wb_data_i = 32'hCAFEF00D;
        #2;
        n_checks++;
        if (bus.stall_o !== 1'b0 || bus.rs2_data_o !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL raw_release got %b/%h want 0/cafef00d", bus.stall_o, bus.rs2_data_o);
        end
        tick();
        idle();
        n_checks++;
        if (bus.busy_cnt_o !== 6'd0) begin
            n_fail++; $display("FAIL raw_cnt got %0d want 0", bus.busy_cnt_o);
        end
    endtask

    task automatic test_waw();
        idle();
        issue(5'd9, 5'd0, 5'd0);
        tick();
        n_checks++;
        if (bus.busy_cnt_o !== 6'd1) begin
            n_fail++; $display("FAIL waw_busy got %0d want 1", bus.busy_cnt_o);
        end
        #2;
        n_checks++;
        if (bus.stall_o !== 1'b1) begin
            n_fail++; $display("FAIL waw_stall got %b want 1", bus.stall_o);
        end
        tick();
        bus.wb_wen_i = 1'b1; bus.wb_rd_i = 5'd9; bus.wb_data_i = 32'h00000099;
        #2;
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL setwins_stall got %b want 0", bus.stall_o);
        end
        tick();
        idle();
        n_checks++;
        if (bus.busy_cnt_o !== 6'd1) begin
            n_fail++; $display("FAIL setwins_cnt got %0d want 1", bus.busy_cnt_o);
        end
        bus.issue_valid_i = 1'b1;
        bus.rs1_addr_i = 5'd9;
        #2;
        n_checks++;
        if (bus.stall_o !== 1'b1 || bus.rs1_data_o !== 32'h00000099) begin
            n_fail++; $display("FAIL setwins_busy got %b/%h want 1/00000099", bus.stall_o, bus.rs1_data_o);
        end
        tick();
        idle();
        bus.wb_wen_i = 1'b1; bus.wb_rd_i = 5'd9;
        tick();
        idle();
    endtask

    task automatic test_flush();
        logic [4:0] rds [3];
        rds = '{5'd1, 5'd2, 5'd4};
        idle();
        for (int k = 0; k < 3; k++) begin
            issue(rds[k], 5'd0, 5'd0);
            tick();
        end
        n_checks++;
        if (bus.busy_cnt_o !== 6'd3) begin
            n_fail++; $display("FAIL flush_pre got %0d want 3", bus.busy_cnt_o);
        end
        issue(5'd6, 5'd0, 5'd0);
        bus.flush_i = 1'b1;
        tick();
        idle();
        n_checks++;
        if (bus.busy_cnt_o !== 6'd0) begin
            n_fail++; $display("FAIL flush_cnt got %0d want 0", bus.busy_cnt_o);
        end
        issue(5'd6, 5'd1, 5'd6);
        #2;
        n_checks++;
        if (bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall got %b want 0", bus.stall_o);
        end
        tick();
        idle();
        bus.flush_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_random();
        exp_t        e;
        exp_t        got;
        int          ecnt;
        logic [4:0]  a;
        idle();
        rst = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy = 32'd0;
        tick();
        for (int c = 0; c < 400; c++) begin
            bus.rs1_addr_i    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.rs2_addr_i    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.issue_valid_i = ($urandom_range(0, 3) != 0);
            bus.issue_wen_i   = ($urandom_range(0, 4) != 0);
            bus.issue_rd_i    = 5'($urandom_range(0, 31));
            bus.wb_wen_i      = ($urandom_range(0, 2) != 0);
            bus.wb_rd_i       = 5'($urandom_range(0, 31));
            bus.wb_data_i     = $urandom;
            bus.flush_i       = ($urandom_range(0, 39) == 0);
            a = bus.rs1_addr_i;
            e.rs1 = (a == 0) ? 32'd0 : (bus.wb_wen_i && bus.wb_rd_i == a) ? bus.wb_data_i : m_regs[a];
            a = bus.rs2_addr_i;
            e.rs2 = (a == 0) ? 32'd0 : (bus.wb_wen_i && bus.wb_rd_i == a) ? bus.wb_data_i : m_regs[a];
            e.stall = bus.issue_valid_i &&
                ((m_busy[bus.rs1_addr_i] && !(bus.wb_wen_i && bus.wb_rd_i == bus.rs1_addr_i)) ||
                 (m_busy[bus.rs2_addr_i] && !(bus.wb_wen_i && bus.wb_rd_i == bus.rs2_addr_i)) ||
                 (bus.issue_wen_i && m_busy[bus.issue_rd_i] &&
                  !(bus.wb_wen_i && bus.wb_rd_i == bus.issue_rd_i)));
            sb_q.push_back(e);
            if (bus.wb_wen_i && bus.wb_rd_i != 0) begin
                m_regs[bus.wb_rd_i] = bus.wb_data_i;
                m_busy[bus.wb_rd_i] = 1'b0;
            end
            if (bus.issue_valid_i && !e.stall && bus.issue_wen_i && bus.issue_rd_i != 0)
                m_busy[bus.issue_rd_i] = 1'b1;
            if (bus.flush_i) m_busy = 32'd0;
            cnt_q.push_back($countones(m_busy));
            #2;
            got = sb_q.pop_front();
            n_checks++;
            if (bus.stall_o !== got.stall) begin
                n_fail++; $display("FAIL rnd_stall c%0d got %b want %b", c, bus.stall_o, got.stall);
            end
            n_checks++;
            if (bus.rs1_data_o !== got.rs1 || bus.rs2_data_o !== got.rs2) begin
                n_fail++; $display("FAIL rnd_read c%0d got %h/%h want %h/%h", c,
                                   bus.rs1_data_o, bus.rs2_data_o, got.rs1, got.rs2);
            end
            tick();
            ecnt = cnt_q.pop_front();
            n_checks++;
            if (bus.busy_cnt_o !== 6'(ecnt)) begin
                n_fail++; $display("FAIL rnd_cnt c%0d got %0d want %0d", c, bus.busy_cnt_o, ecnt);
            end
        end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();
        n_checks++;
        if (bus.busy_cnt_o !== 6'd0 || bus.stall_o !== 1'b0) begin
            n_fail++; $display("FAIL init_state got %0d/%b want 0/0", bus.busy_cnt_o, bus.stall_o);
        end
        test_reset();
        test_bypass();
        test_raw();
        test_waw();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Integer register file with a write-back scoreboard. It sits between the decode stage and the write-back path. It answers the decode stage's two combinational read requests and accepts one write per cycle from write-back. It also tracks which architectural registers have a write in flight, and raises a stall when the instruction in decode would read or overwrite such a register.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers; fixed at 32 (5-bit addresses), x0 hardwired to zero

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- rs1_addr_i  input  5  read port 1 address from decode
- rs2_addr_i  input  5  read port 2 address from decode
- rs1_data_o  output  XLEN  read port 1 data, combinational
- rs2_data_o  output  XLEN  read port 2 data, combinational
- issue_valid_i  input  1  decode has a valid instruction this cycle
- issue_wen_i  input  1  that instruction writes rd (decode's reg_wen)
- issue_rd_i  input  5  destination register of that instruction
- stall_o  output  1  hold decode/fetch this cycle; instruction not issued
- wb_wen_i  input  1  write-back write enable
- wb_rd_i  input  5  write-back destination
- wb_data_i  input  XLEN  write-back data
- flush_i  input  1  pipeline flush; clear all busy bits
- busy_cnt_o  output  6  number of registers currently marked busy, registered

## Operation
- Storage: regs[1..31], XLEN each. x0 is not stored and always reads 0.
- Scoreboard: busy[1..31], 1 bit each. busy[0] is constant 0.
- Write: when wb_wen_i=1 and wb_rd_i≠0, regs[wb_rd_i] ← wb_data_i at the clock edge, and busy[wb_rd_i] clears unless the set rule below applies. A write-back to x0 is ignored entirely.
- Read: rsN_data_o = 0 if rsN_addr_i=0. Otherwise it is wb_data_i if wb_wen_i and wb_rd_i=rsN_addr_i (same-cycle write-through bypass). Otherwise it is regs[rsN_addr_i].
- Effective busy of register r this cycle: eb[r] = busy[r] and not (wb_wen_i and wb_rd_i=r).
- stall_o = issue_valid_i and (eb[rs1_addr_i] or eb[rs2_addr_i] or (issue_wen_i and eb[issue_rd_i])). It is purely combinational.
  - The RAW check is conservative: both source fields are checked even if the instruction does not use them, and decode zeroes unused addresses.
  - The WAW check guarantees at most one outstanding writer per register, so 1 busy bit suffices.
- Issue: when issue_valid_i=1, stall_o=0, issue_wen_i=1 and issue_rd_i≠0, then busy[issue_rd_i] ← 1 at the clock edge.
- Same-cycle set and clear on the same register: set wins (the new writer owns the register).
- flush_i=1: all busy bits ← 0 at the edge, overriding any issue set that cycle. A write-back that cycle still updates regs. flush_i does not gate stall_o.
- busy_cnt_o: registered population count of busy after the update, range 0..31.

## Timing
- Reset (rst=0, asynchronous): all regs=0, all busy=0, busy_cnt_o=0. rs*_data_o then reads 0 unless bypassed. stall_o=0 while busy is 0.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Release is synchronous to the next edge and takes no other action.
- Read latency: 0 cycles (combinational), including the bypass path.
- Write visible in regs on the edge after wb_wen_i. It is visible via bypass in the same cycle.
- Busy set becomes visible to stall_o in the cycle after issue. Busy clear takes effect in the same cycle as write-back, via eb.
- busy_cnt_o lags the busy vector by 0 cycles: it is registered alongside busy from the same next-state.
- No other latency; the block has no internal pipeline.

## Test plan
- Reset then read: assert rst=0 mid-run with busy bits set, release, read x5/x31 → data 0, stall_o=0, busy_cnt_o=0.
- Write/read with bypass:
  - wb x3=0x12345678 and read rs1=x3 in the same cycle → rs1_data_o=0x12345678.
  - Next cycle, no wb → still 0x12345678.
  - wb to x0 with 0xFFFFFFFF → rs reads of x0 return 0.
- RAW stall:
  - Issue rd=x7 (wen=1), next cycle issue_valid with rs2=x7 → stall_o=1.
  - Hold for 3 cycles, then wb x7 → stall_o=0 that same cycle, with rs2_data_o = wb data.
- WAW and set-wins:
  - Issue rd=x9 → busy.
  - Issue rd=x9 again → stall_o=1.
  - Cycle with wb x9 and an issue writing x9 → no stall, busy[x9] stays 1, busy_cnt_o unchanged.
- Flush: issue writes to x1, x2, x4 → busy_cnt_o=3. flush_i=1 with a simultaneous issue rd=x6 → next cycle busy_cnt_o=0, no stall on x1/x6.
- Randomised issue/wb sequence against a reference model: busy_cnt_o matches, and no read returns stale data when stall_o=0.
